// File: rtl/tsn_desc_fifo_arbiter.sv
// -----------------------------------------------------------------------------
// tsn_desc_fifo_arbiter
//
// Shares one show-ahead descriptor FIFO (DW bits x 2^AW entries) between
// NUM_REQ descriptor producers. A round-robin arbiter grants at most one write
// per cycle. Back-pressure is based on FIFO occupancy, and that occupancy
// includes the registered write still in flight. A software flush sequence
// drains the last write, pulses the FIFO's active-high aclr for CLR_CYCLES
// cycles and then recovers. Accepted writes are counted in a wrapping 16-bit
// counter.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_req[k]         requester k has a descriptor; held until acked
//   i_data           requester k drives bits [k*DW +: DW]
//   o_ack[k]         one-hot grant pulse (combinational); descriptor consumed
//   o_fifo_data      registered descriptor towards FIFO data
//   o_fifo_wrreq     registered FIFO write strobe
//   o_fifo_aclr      FIFO asynchronous clear, active high
//   i_fifo_usedw     FIFO fill level (wraps to 0 when full)
//   i_fifo_full      FIFO full flag
//   i_flush          single-cycle flush request
//   o_flush_busy     flush sequence in progress
//   o_wr_cnt         accepted-write counter, wraps at 16 bits
//
// Handshake: a requester raises i_req[k] with stable i_data slice k and keeps
// both until it sees o_ack[k]=1 in some cycle. That cycle is the transfer. In
// the next cycle it may drop i_req[k] or present a new descriptor. If i_req[k]
// stays high, that is a new descriptor.
// -----------------------------------------------------------------------------
module tsn_desc_fifo_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DW          = 71,
    parameter int AW          = 5,
    parameter int FULL_MARGIN = 2,
    parameter int CLR_CYCLES  = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NUM_REQ-1:0]    i_req,
    input  logic [NUM_REQ*DW-1:0] i_data,
    output logic [NUM_REQ-1:0]    o_ack,
    output logic [DW-1:0]         o_fifo_data,
    output logic                  o_fifo_wrreq,
    output logic                  o_fifo_aclr,
    input  logic [AW-1:0]         i_fifo_usedw,
    input  logic                  i_fifo_full,
    input  logic                  i_flush,
    output logic                  o_flush_busy,
    output logic [15:0]           o_wr_cnt
);

    localparam int PW = $clog2(NUM_REQ);
    localparam logic [AW:0] OCC_FULL  = (AW+1)'(1 << AW);
    localparam logic [AW:0] OCC_LIMIT = (AW+1)'((1 << AW) - FULL_MARGIN);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_DRAIN   = 2'd1,
        S_CLR     = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      clr_cnt_q, clr_cnt_d;
    logic [PW-1:0]   ptr_q;
    logic            wrreq_q;
    logic [DW-1:0]   data_q;
    logic [15:0]     wr_cnt_q;

    logic [AW:0]     occ;
    logic            room;
    logic            found;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   cand;
    logic            grant;

    // Occupancy counts the write that is still in flight. usedw reads 0 when
    // the FIFO is full, so the full flag overrides it.
    always_comb begin
        if (i_fifo_full) begin
            occ = OCC_FULL;
        end else begin
            occ = {1'b0, i_fifo_usedw} + {{AW{1'b0}}, wrreq_q};
        end
    end

    // A flush request takes priority over arbitration in its own cycle.
    assign room = (state_q == S_RUN) && !i_flush && !i_fifo_full && (occ < OCC_LIMIT);

    // Round-robin search. It starts one past the last winner and wraps, so
    // idle requesters are skipped without losing a cycle.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = PW'((int'(ptr_q) + i) % NUM_REQ);
            if (!found && i_req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign grant = i_rst_n && room && found;
    assign o_ack = grant ? (NUM_REQ'(1) << win_idx) : '0;

    // Write path: the granted descriptor is registered and written next cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q    <= PW'(NUM_REQ - 1);
            wrreq_q  <= 1'b0;
            data_q   <= '0;
            wr_cnt_q <= '0;
        end else begin
            wrreq_q <= grant;
            if (grant) begin
                ptr_q    <= win_idx;
                data_q   <= i_data[int'(win_idx)*DW +: DW];
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
        end
    end

    assign o_fifo_wrreq = wrreq_q;
    assign o_fifo_data  = data_q;
    assign o_wr_cnt     = wr_cnt_q;

    // Flush FSM: state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_RUN;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Flush FSM: next state. S_DRAIN lets the last registered write land
    // before aclr is asserted.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            S_RUN: begin
                if (i_flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d   = S_CLR;
                clr_cnt_d = 4'(CLR_CYCLES);
            end
            S_CLR: begin
                clr_cnt_d = clr_cnt_q - 4'd1;
                if (clr_cnt_q == 4'd1) begin
                    state_d = S_RECOVER;
                end
            end
            S_RECOVER: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // Flush FSM: outputs.
    always_comb begin
        o_fifo_aclr  = (state_q == S_CLR);
        o_flush_busy = (state_q != S_RUN);
    end

endmodule

// File: tb/tb_tsn_desc_fifo_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for tsn_desc_fifo_arbiter.
//
// The bench contains a FIFO model that serves as the DUT's environment. A
// reference model runs on the falling edge. It predicts each cycle's grant
// from the round-robin rule (smallest rotational distance from the last
// winner) and from the occupancy rules. When it predicts a grant, it pushes
// the expected descriptor into exp_q. A monitor on the rising edge pops exp_q
// whenever the DUT presents o_fifo_wrreq and compares the data. Directed
// phases cover the following cases:
//   - round-robin with all requesters active
//   - back-pressure
//   - flush timing
//   - sparse requesters
//   - the data path
//   - reset during the clear phase
// A random phase follows the directed phases.
// -----------------------------------------------------------------------------
module tb_tsn_desc_fifo_arbiter;

    localparam int NR    = 4;
    localparam int DW    = 71;
    localparam int AW    = 5;
    localparam int MARG  = 2;
    localparam int CLR   = 3;
    localparam int DEPTH = 1 << AW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 i_rst_n;
    logic [NR-1:0]        i_req;
    logic [NR*DW-1:0]     i_data;
    logic [NR-1:0]        o_ack;
    logic [DW-1:0]        o_fifo_data;
    logic                 o_fifo_wrreq;
    logic                 o_fifo_aclr;
    logic [AW-1:0]        i_fifo_usedw;
    logic                 i_fifo_full;
    logic                 i_flush;
    logic                 o_flush_busy;
    logic [15:0]          o_wr_cnt;

    tsn_desc_fifo_arbiter #(
        .NUM_REQ(NR), .DW(DW), .AW(AW), .FULL_MARGIN(MARG), .CLR_CYCLES(CLR)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (i_rst_n),
        .i_req        (i_req),
        .i_data       (i_data),
        .o_ack        (o_ack),
        .o_fifo_data  (o_fifo_data),
        .o_fifo_wrreq (o_fifo_wrreq),
        .o_fifo_aclr  (o_fifo_aclr),
        .i_fifo_usedw (i_fifo_usedw),
        .i_fifo_full  (i_fifo_full),
        .i_flush      (i_flush),
        .o_flush_busy (o_flush_busy),
        .o_wr_cnt     (o_wr_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input bit ok, input string name,
                         input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- FIFO environment model ----------------
    logic [DW-1:0] fifo_q[$];
    logic [AW:0]   fifo_cnt = '0;
    logic          rd_en;

    assign i_fifo_usedw = fifo_cnt[AW-1:0];
    assign i_fifo_full  = (fifo_cnt == (AW+1)'(DEPTH));

    always @(posedge clk) begin
        if (o_fifo_aclr) begin
            fifo_q.delete();
        end else begin
            if (rd_en && fifo_q.size() > 0) void'(fifo_q.pop_front());
            if (o_fifo_wrreq && fifo_q.size() < DEPTH) fifo_q.push_back(o_fifo_data);
        end
        fifo_cnt <= (AW+1)'(fifo_q.size());
    end

    // ---------------- scoreboard / reference model ----------------
    logic [DW-1:0] exp_q[$];
    int            m_ptr = NR - 1;
    logic [15:0]   m_cnt = '0;
    int            fl = 0;            // remaining flush cycles, 0 = running
    bit            prev_grant = 1'b0;
    logic [NR-1:0] last_ack = '0;

    always @(negedge clk) begin
        int best, bestd, d, occ;
        bit room;
        logic [NR-1:0] exp_ack;
        if (!i_rst_n) begin
            m_ptr      = NR - 1;
            m_cnt      = '0;
            fl         = 0;
            prev_grant = 1'b0;
            last_ack   = '0;
            exp_q.delete();
            check({o_ack, o_fifo_wrreq, o_fifo_aclr, o_flush_busy, o_wr_cnt, o_fifo_data} == '0,
                  "reset_outputs",
                  {o_ack, o_fifo_wrreq, o_fifo_aclr, o_flush_busy, o_wr_cnt}, 0);
        end else begin
            check(o_flush_busy == (fl > 0), "flush_busy", o_flush_busy, fl > 0);
            check(o_fifo_aclr == (fl >= 2 && fl <= CLR + 1), "fifo_aclr",
                  o_fifo_aclr, fl >= 2 && fl <= CLR + 1);
            check(o_fifo_wrreq == prev_grant, "wrreq", o_fifo_wrreq, prev_grant);
            check(o_wr_cnt == m_cnt, "wr_cnt", o_wr_cnt, m_cnt);
            occ  = int'(fifo_cnt) + int'(prev_grant);
            room = (fl == 0) && !i_flush && (occ < DEPTH - MARG);
            best  = -1;
            bestd = NR;
            for (int k = 0; k < NR; k++) begin
                if (i_req[k]) begin
                    d = (k - m_ptr - 1 + 2 * NR) % NR;
                    if (d < bestd) begin
                        bestd = d;
                        best  = k;
                    end
                end
            end
            exp_ack = (room && best >= 0) ? NR'(1 << best) : '0;
            check(o_ack == exp_ack, "ack", o_ack, exp_ack);
            if (exp_ack != '0) begin
                exp_q.push_back(i_data[best*DW +: DW]);
                m_ptr = best;
                m_cnt = m_cnt + 16'd1;
            end
            prev_grant = (exp_ack != '0);
            if (fl == 0 && i_flush) fl = CLR + 2;
            else if (fl > 0)        fl = fl - 1;
            last_ack = o_ack;
        end
    end

    // Monitor: every FIFO write must match the oldest expected descriptor.
    always @(posedge clk) begin
        if (i_rst_n && o_fifo_wrreq) begin
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_write", o_fifo_data, 0);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                check(o_fifo_data == e, "write_data", o_fifo_data, e);
            end
        end
    end

    // ---------------- driver ----------------
    logic [NR-1:0] req_mask = '0;
    int req_pct   = 0;
    int hold_pct  = 0;
    int rd_pct    = 0;
    int flush_pct = 0;   // per 200 cycles

    function automatic logic [DW-1:0] rand_desc();
        return DW'({$urandom, $urandom, $urandom});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < NR; k++) begin
            if (last_ack[k]) begin
                i_req[k] = req_mask[k] && ($urandom_range(99) < hold_pct);
                if (i_req[k]) i_data[k*DW +: DW] = rand_desc();
            end else if (!i_req[k] && req_mask[k] && ($urandom_range(99) < req_pct)) begin
                i_req[k] = 1'b1;
                i_data[k*DW +: DW] = rand_desc();
            end
        end
        rd_en   = ($urandom_range(99) < rd_pct);
        i_flush = ($urandom_range(199) < flush_pct);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        req_mask  = '0;
        rd_pct    = 100;
        flush_pct = 0;
        n = 0;
        while ((i_req != '0 || exp_q.size() != 0 || fifo_cnt != '0 || o_flush_busy) && n < budget) begin
            step();
            n++;
        end
        check(n < budget, "idle_timeout", n, budget);
        rd_pct = 0;
    endtask

    int busy_n, aclr_n;
    bit seen_aclr;
    localparam logic [DW-1:0] VAL = 71'h55_0123_4567_89AB_CDEF;

    initial begin
        i_rst_n = 1'b0;
        i_req   = '0;
        i_data  = '0;
        i_flush = 1'b0;
        rd_en   = 1'b0;
        repeat (3) step();
        i_rst_n = 1'b1;
        repeat (2) step();

        // Round-robin, all requesting, empty FIFO, no reads.
        req_mask = '1;
        req_pct  = 100;
        hold_pct = 100;
        repeat (9) step();
        check(o_wr_cnt == 16'd8, "rr_cnt_after_8", o_wr_cnt, 8);

        // Back-pressure: writes stop at 30 entries.
        repeat (40) step();
        check(fifo_cnt == 30, "bp_fill_level", fifo_cnt, 30);
        check(o_wr_cnt == 16'd30, "bp_write_count", o_wr_cnt, 30);
        step();
        rd_en = 1'b1;
        repeat (6) step();
        check(o_wr_cnt == 16'd31, "bp_one_more", o_wr_cnt, 31);
        check(fifo_cnt == 30, "bp_refill_level", fifo_cnt, 30);

        // Flush with requests still active.
        step();
        i_flush = 1'b1;
        busy_n = 0;
        aclr_n = 0;
        seen_aclr = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (o_flush_busy) busy_n++;
            if (o_fifo_aclr) begin
                aclr_n++;
                seen_aclr = 1'b1;
            end
            if (seen_aclr && o_flush_busy && !o_fifo_aclr)
                check(fifo_cnt == 0, "flush_emptied", fifo_cnt, 0);
        end
        check(busy_n == CLR + 2, "flush_busy_len", busy_n, CLR + 2);
        check(aclr_n == CLR, "flush_aclr_len", aclr_n, CLR);

        // Sparse requesters.
        wait_idle(300);
        req_mask = 4'b1010;
        req_pct  = 100;
        hold_pct = 100;
        repeat (12) step();

        // Single descriptor through the data path.
        wait_idle(300);
        step();
        i_data[2*DW +: DW] = VAL;
        i_req[2] = 1'b1;
        repeat (4) step();
        check(fifo_q.size() == 1, "dp_fifo_size", fifo_q.size(), 1);
        if (fifo_q.size() > 0) check(fifo_q[0] == VAL, "dp_fifo_q", fifo_q[0], VAL);

        // Random traffic with reads and occasional flushes.
        req_mask  = '1;
        req_pct   = 60;
        hold_pct  = 50;
        rd_pct    = 45;
        flush_pct = 1;
        repeat (1500) step();

        // Reset while aclr is asserted.
        wait_idle(400);
        step();
        i_flush = 1'b1;
        step();
        step();
        check(o_fifo_aclr == 1'b1, "aclr_before_reset", o_fifo_aclr, 1);
        i_rst_n = 1'b0;
        i_req   = '0;
        #1;
        check({o_fifo_aclr, o_flush_busy, o_fifo_wrreq, o_wr_cnt} == '0, "async_reset_drop",
              {o_fifo_aclr, o_flush_busy, o_fifo_wrreq, o_wr_cnt}, 0);
        repeat (2) step();
        i_rst_n = 1'b1;
        req_mask = '1;
        req_pct  = 100;
        hold_pct = 100;
        step();
        #1;
        check(o_ack == 4'b0001, "first_prio_after_reset", o_ack, 1);
        req_pct  = 70;
        hold_pct = 40;
        rd_pct   = 50;
        repeat (300) step();

        wait_idle(400);
        check(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
